vc_test_delay_queue: RTL and testbench
======================================

// Module: vc_test_delay_queue
// PURPOSE
//  Test-infrastructure delay element between a vc_TestSource and a vc_TestSink.
//  Buffers up to p_num_entries val/rdy messages and holds each one back by a
//  per-message delay: fixed, pseudo-random, or applied to the first message only.
//  Provides multi-entry, randomised back-pressure for unit-test harnesses.
// PARAMETERS
//  p_msg_nbits    8        message width in bits
//  p_num_entries  4        queue depth; power of two, >= 2
//  p_lfsr_seed    16'hACE1 LFSR seed loaded on reset; must be nonzero
// PORTS
//  clk        in   1            clock; all state updates on posedge
//  reset      in   1            synchronous, active-high reset
//  delay_mode in   2            0 FIXED, 1 RANDOM, 2 FIRST_ONLY, 3 treated as FIXED
//  delay_amt  in   32           delay amount (FIXED) or random bound (RANDOM)
//  in_val     in   1            input message valid
//  in_rdy     out  1            input ready
//  in_msg     in   p_msg_nbits  input message
//  out_val    out  1            output message valid
//  out_rdy    in   1            output ready
//  out_msg    out  p_msg_nbits  output message (head entry)
// BEHAVIOUR
//  - Reset: queue empty, pointers 0, storage 0, LFSR = p_lfsr_seed; in_rdy=0,
//    out_val=0, out_msg=0 while reset high. Reset mid-operation drops all entries.
//  - Transfer occurs on posedge when val && rdy are both high on that interface.
//  - in_rdy = !reset && !full. It does not depend on out_rdy (no bypass when full).
//  - Per-message delay d is computed and stored with the message at enqueue:
//    FIXED: d = delay_amt (full 32 bits).
//    RANDOM: d = {16'b0, lfsr} % ({16'b0, delay_amt[15:0]} + 17'd1); 17-bit add, no overflow.
//    FIRST_ONLY: d = delay_amt for the first message after reset; d = 0 afterwards.
//  - delay_mode/delay_amt changes affect only messages enqueued afterwards.
//  - LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances once per accepted input
//    message, never per cycle, so the delay sequence does not depend on sink stalls.
//  - Head countdown: when an entry becomes head (enqueue into empty queue, or
//    dequeue with entries remaining), head_cnt <= that entry's d on the same edge.
//    While head_cnt > 0 it decrements each cycle. out_val = !empty && head_cnt==0.
//  - Latency: message accepted at edge E into an empty queue is presented
//    (out_val=1) in the cycle after edge E+d. d=0 gives 1-cycle latency and
//    1 msg/cycle throughput.
//  - out_val, once high, stays high with out_msg stable until out_rdy is high.
//  - Simultaneous enqueue and dequeue: both take effect; count unchanged. Full: no
//    enqueue even if dequeuing that cycle. Pointers wrap mod p_num_entries.
//  - trace task prints occupancy and head_cnt, e.g. "2:03".
// CONFIGURATION
//  VC_TEST_DELAY_QUEUE_STATS_EN defined: 32-bit counters num_msgs (dequeues) and
//    num_stall_cycles (out_val && !out_rdy) are cleared on reset, readable
//    hierarchically, and appended to the trace as " m:<num_msgs>".
//  Undefined: the counters and the trace suffix are absent. Port list is identical.
// STRUCTURE
//  vc-test-delay-defs.v header: `define VC_TEST_DELAY_MODE_{FIXED,RANDOM,FIRST_ONLY}
//    values 0/1/2 and the default LFSR seed; shared with harnesses.
//  Sub-module vc_test_lfsr16 (clk, reset, en, out[15:0], p_seed parameter).
//  Storage, pointers and head countdown are inline in this module.
// TESTING (TestHarness src > vc_test_delay_queue > sink, ordered 8-bit input set)
//  FIXED, delay_amt=0, sink always ready -> back-to-back out_val; all msgs in order; done.
//  FIXED, delay_amt=3, one msg 8'h2a -> accepted at edge E; out_val first high in cycle after edge E+3.
//  FIXED, delay_amt=10, sink stalled -> 4 accepted, then in_rdy=0 while full; order preserved.
//  RANDOM, delay_amt=5, seed 16'hACE1 -> every d in 0..5; two runs give identical traces.
//  FIRST_ONLY, delay_amt=10 -> first msg waits 10 cycles; rest flow at 1 msg/cycle.
//  Reset asserted with 3 msgs queued -> next cycle out_val=0; after release, queue empty, LFSR reseeded.

Source files
------------

// File: rtl/vc_test_delay_queue_pkg.sv
// ----------------------------------------------------------------------------
// vc_test_delay_queue_pkg
//   Shared definitions for the test delay queue and its harnesses: delay mode
//   encodings, default LFSR seed and the random-delay helper.
// ----------------------------------------------------------------------------
package vc_test_delay_queue_pkg;

   typedef enum logic [1:0] {
      DELAY_FIXED      = 2'd0,
      DELAY_RANDOM     = 2'd1,
      DELAY_FIRST_ONLY = 2'd2,
      DELAY_FIXED_ALT  = 2'd3   // decoded exactly like DELAY_FIXED
   } delay_mode_e;

   localparam logic [15:0] DEFAULT_LFSR_SEED = 16'hACE1;

   // Random delay in 0..bound. The span is a 17-bit sum so bound=16'hFFFF
   // cannot wrap to a zero divisor.
   function automatic logic [31:0] random_delay(input logic [15:0] lfsr,
                                                input logic [15:0] bound);
      logic [16:0] span;
      span = {1'b0, bound} + 17'd1;
      return {16'b0, lfsr} % {15'b0, span};
   endfunction

endpackage

// File: rtl/vc_test_delay_queue_if.sv
// ----------------------------------------------------------------------------
// vc_test_delay_queue_if
//   Val/rdy handshake bundle around the delay queue.
//   in_val/in_rdy/in_msg    : source -> queue
//   out_val/out_rdy/out_msg : queue -> sink
//   master : harness side (drives in_val, in_msg, out_rdy)
//   slave  : queue side   (drives in_rdy, out_val, out_msg)
// ----------------------------------------------------------------------------
interface vc_test_delay_queue_if #(
   parameter int unsigned p_msg_nbits = 8
) ();

   logic                   in_val;
   logic                   in_rdy;
   logic [p_msg_nbits-1:0] in_msg;
   logic                   out_val;
   logic                   out_rdy;
   logic [p_msg_nbits-1:0] out_msg;

   modport master (
      output in_val, in_msg, out_rdy,
      input  in_rdy, out_val, out_msg
   );

   modport slave (
      input  in_val, in_msg, out_rdy,
      output in_rdy, out_val, out_msg
   );

endinterface

// File: rtl/vc_test_lfsr16.sv
// ----------------------------------------------------------------------------
// vc_test_lfsr16
//   16-bit Fibonacci LFSR, taps 16,14,13,11 (right-shifting form).
//   clk, reset : synchronous active-high reset loads p_seed
//   en         : advance one step on this edge
//   out        : current LFSR state
// ----------------------------------------------------------------------------
module vc_test_lfsr16 #(
   parameter logic [15:0] p_seed = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   output logic [15:0] out
);

   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (en) begin
         lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_q <= p_seed;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign out = lfsr_q;

endmodule

// File: rtl/vc_test_delay_queue.sv
// ----------------------------------------------------------------------------
// vc_test_delay_queue
//   Test-harness delay element: buffers up to p_num_entries val/rdy messages
//   and holds each back by a per-message delay (fixed, pseudo-random, or on
//   the first message after reset only). The delay is fixed at enqueue time.
//   clk, reset  : synchronous active-high reset, drops all entries
//   delay_mode  : 0 FIXED, 1 RANDOM, 2 FIRST_ONLY, 3 FIXED
//   delay_amt   : delay (FIXED/FIRST_ONLY) or random bound (RANDOM, [15:0])
//   bus         : in_val/in_rdy/in_msg and out_val/out_rdy/out_msg
// Optional: VC_TEST_DELAY_QUEUE_STATS_EN adds num_msgs and num_stall_cycles
//   counters, readable hierarchically.
// ----------------------------------------------------------------------------
module vc_test_delay_queue
   import vc_test_delay_queue_pkg::*;
#(
   parameter int unsigned p_msg_nbits   = 8,
   parameter int unsigned p_num_entries = 4,
   parameter logic [15:0] p_lfsr_seed   = DEFAULT_LFSR_SEED
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            delay_mode,
   input  logic [31:0]           delay_amt,
   vc_test_delay_queue_if.slave  bus
);

   localparam int unsigned     AW       = $clog2(p_num_entries);
   localparam int unsigned     CW       = AW + 1;
   localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]   CNT_FULL = CW'(p_num_entries);

   logic [p_msg_nbits-1:0] msg_q [p_num_entries];
   logic [p_msg_nbits-1:0] msg_d [p_num_entries];
   logic [31:0]            dly_q [p_num_entries];
   logic [31:0]            dly_d [p_num_entries];
   logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]          rd_ptr_nxt;
   logic [CW-1:0]          count_q, count_d;
   logic [31:0]            head_cnt_q, head_cnt_d;
   logic                   first_done_q, first_done_d;

   logic [15:0]            lfsr;
   logic [31:0]            new_dly;
   delay_mode_e            mode;
   logic                   empty, full, enq, deq;
   logic                   in_rdy, out_val;

   // Advances only on accepted input so the delay sequence is independent
   // of sink stalls.
   vc_test_lfsr16 #(.p_seed(p_lfsr_seed)) lfsr_u (
      .clk   (clk),
      .reset (reset),
      .en    (enq),
      .out   (lfsr)
   );

   assign mode    = delay_mode_e'(delay_mode);
   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_FULL);
   assign in_rdy  = !reset && !full;
   assign out_val = !reset && !empty && (head_cnt_q == '0);
   assign enq     = bus.in_val && in_rdy;
   assign deq     = out_val && bus.out_rdy;

   assign bus.in_rdy  = in_rdy;
   assign bus.out_val = out_val;
   assign bus.out_msg = reset ? '0 : msg_q[rd_ptr_q];

   always_comb begin
      unique case (mode)
         DELAY_RANDOM:     new_dly = random_delay(lfsr, delay_amt[15:0]);
         DELAY_FIRST_ONLY: new_dly = first_done_q ? '0 : delay_amt;
         default:          new_dly = delay_amt;
      endcase
   end

   always_comb begin
      msg_d        = msg_q;
      dly_d        = dly_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      head_cnt_d   = head_cnt_q;
      first_done_d = first_done_q;
      rd_ptr_nxt   = rd_ptr_q + PTR_ONE;

      if (enq) begin
         msg_d[wr_ptr_q] = bus.in_msg;
         dly_d[wr_ptr_q] = new_dly;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
         first_done_d    = 1'b1;
      end
      if (deq) begin
         rd_ptr_d = rd_ptr_nxt;
      end

      unique case ({enq, deq})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      // A new head loads its own delay on the edge it becomes head. When the
      // last entry leaves while one arrives, the arriving delay is not yet in
      // storage, so it is taken straight from new_dly.
      if (deq && (count_q > CNT_ONE)) begin
         head_cnt_d = dly_q[rd_ptr_nxt];
      end else if (enq && (deq || empty)) begin
         head_cnt_d = new_dly;
      end else if (head_cnt_q != '0) begin
         head_cnt_d = head_cnt_q - 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         msg_q        <= '{default: '0};
         dly_q        <= '{default: '0};
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         head_cnt_q   <= '0;
         first_done_q <= 1'b0;
      end else begin
         msg_q        <= msg_d;
         dly_q        <= dly_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         head_cnt_q   <= head_cnt_d;
         first_done_q <= first_done_d;
      end
   end

`ifdef VC_TEST_DELAY_QUEUE_STATS_EN
   logic [31:0] num_msgs_q, num_msgs_d;
   logic [31:0] num_stall_cycles_q, num_stall_cycles_d;
   logic [31:0] num_msgs;
   logic [31:0] num_stall_cycles;

   always_comb begin
      num_msgs_d         = num_msgs_q;
      num_stall_cycles_d = num_stall_cycles_q;
      if (deq) begin
         num_msgs_d = num_msgs_q + 32'd1;
      end
      if (out_val && !bus.out_rdy) begin
         num_stall_cycles_d = num_stall_cycles_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         num_msgs_q         <= '0;
         num_stall_cycles_q <= '0;
      end else begin
         num_msgs_q         <= num_msgs_d;
         num_stall_cycles_q <= num_stall_cycles_d;
      end
   end

   assign num_msgs         = num_msgs_q;
   assign num_stall_cycles = num_stall_cycles_q;
`endif

endmodule

// File: tb/tb_vc_test_delay_queue.sv
// ----------------------------------------------------------------------------
// tb_vc_test_delay_queue
//   Directed and randomized stimulus against a queue/timestamp reference model.
// ----------------------------------------------------------------------------
module tb_vc_test_delay_queue;
   import vc_test_delay_queue_pkg::*;

   localparam int unsigned NB   = 8;
   localparam int unsigned NE   = 4;
   localparam logic [15:0] SEED = 16'hACE1;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  delay_mode;
   logic [31:0] delay_amt;

   vc_test_delay_queue_if #(.p_msg_nbits(NB)) bus ();

   vc_test_delay_queue #(
      .p_msg_nbits   (NB),
      .p_num_entries (NE),
      .p_lfsr_seed   (SEED)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .delay_mode (delay_mode),
      .delay_amt  (delay_amt),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   // Reference model: message queue with stored delays; the head becomes
   // visible once the edge count reaches (edge it became head) + its delay.
   logic [NB-1:0]   m_msg [$];
   logic [31:0]     m_dly [$];
   longint unsigned n_edge    = 0;
   longint unsigned head_edge = 0;
   logic [15:0]     m_lfsr    = SEED;
   bit              m_first_done = 1'b0;
   logic [NB-1:0]   next_msg  = '0;
   logic            seen_out_val;
   int              errors = 0;
   int              checks = 0;
   int              lat;
   logic            v, r;

   function automatic logic [15:0] ref_lfsr_next(input logic [15:0] s);
      int unsigned x, b;
      x = int'(s);
      b = (x ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 1;
      return 16'((x >> 1) | (b << 15));
   endfunction

   function automatic logic model_out_val();
      if (reset || m_msg.size() == 0) return 1'b0;
      return (n_edge >= head_edge + 64'(m_dly[0]));
   endfunction

   task automatic check_cycle();
      logic exp_rdy, exp_val;
      exp_rdy = !reset && (m_msg.size() < NE);
      exp_val = model_out_val();
      seen_out_val = bus.out_val;
      checks++;
      assert (bus.in_rdy === exp_rdy) else begin
         errors++;
         $error("FAIL in_rdy obs=%b exp=%b t=%0t", bus.in_rdy, exp_rdy, $time);
      end
      checks++;
      assert (bus.out_val === exp_val) else begin
         errors++;
         $error("FAIL out_val obs=%b exp=%b t=%0t", bus.out_val, exp_val, $time);
      end
      if (reset) begin
         checks++;
         assert (bus.out_msg === '0) else begin
            errors++;
            $error("FAIL out_msg_reset obs=%h exp=00 t=%0t", bus.out_msg, $time);
         end
      end else if (exp_val) begin
         checks++;
         assert (bus.out_msg === m_msg[0]) else begin
            errors++;
            $error("FAIL out_msg obs=%h exp=%h t=%0t", bus.out_msg, m_msg[0], $time);
         end
      end
   endtask

   task automatic model_edge();
      logic        enq, deq;
      int unsigned sz;
      logic [31:0] d;
      enq = !reset && bus.in_val && (m_msg.size() < NE);
      deq = model_out_val() && bus.out_rdy;
      n_edge++;
      if (reset) begin
         m_msg.delete();
         m_dly.delete();
         m_lfsr       = SEED;
         m_first_done = 1'b0;
         return;
      end
      sz = m_msg.size();
      if (deq) begin
         void'(m_msg.pop_front());
         void'(m_dly.pop_front());
      end
      if (enq) begin
         case (delay_mode)
            2'd1:    d = 32'(int'(m_lfsr) % (int'(delay_amt[15:0]) + 1));
            2'd2:    d = m_first_done ? 32'd0 : delay_amt;
            default: d = delay_amt;
         endcase
         m_msg.push_back(bus.in_msg);
         m_dly.push_back(d);
         m_lfsr       = ref_lfsr_next(m_lfsr);
         m_first_done = 1'b1;
         next_msg     = next_msg + 1'b1;
      end
      if ((deq && m_msg.size() > 0) || (enq && sz == 0)) head_edge = n_edge;
   endtask

   // One cycle: drive, sample, advance model, cross the edge.
   task automatic step(input logic in_v, input logic out_r);
      bus.in_val  = in_v;
      bus.in_msg  = next_msg;
      bus.out_rdy = out_r;
      #1;
      check_cycle();
      model_edge();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic trace();
      $display("trace %0d:%0d", dut.count_q, dut.head_cnt_q);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      reset = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      delay_mode  = 2'd0;
      delay_amt   = 32'd0;
      bus.in_val  = 1'b0;
      bus.in_msg  = '0;
      bus.out_rdy = 1'b0;
      @(negedge clk);
      do_reset();

      // FIXED 0: back-to-back flow
      repeat (12) step(1'b1, 1'b1);
      repeat (3)  step(1'b0, 1'b1);

      // FIXED 3: single message latency
      delay_amt = 32'd3;
      next_msg  = 8'h2a;
      step(1'b1, 1'b1);
      lat = 0;
      seen_out_val = 1'b0;
      while (seen_out_val !== 1'b1 && lat < 20) begin
         step(1'b0, 1'b1);
         lat++;
         trace();
      end
      checks++;
      assert (lat === 4) else begin
         errors++;
         $error("FAIL latency_d3 obs=%0d exp=4", lat);
      end
      repeat (2) step(1'b0, 1'b1);

      // FIXED 10 with stalled sink: fill, hold, drain in order
      delay_amt = 32'd10;
      repeat (8)  step(1'b1, 1'b0);
      trace();
      repeat (60) step(1'b0, 1'b1);

      // RANDOM 5, twice from reset with the same seed
      for (int run = 0; run < 2; run++) begin
         do_reset();
         delay_mode = 2'd1;
         delay_amt  = 32'd5;
         for (int i = 0; i < 150; i++) begin
            v = ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 3) != 0);
            step(v, r);
         end
         repeat (20) step(1'b0, 1'b1);
      end

      // FIRST_ONLY 10
      do_reset();
      delay_mode = 2'd2;
      delay_amt  = 32'd10;
      repeat (24) step(1'b1, 1'b1);
      repeat (6)  step(1'b0, 1'b1);

      // Mode 3 behaves as FIXED
      delay_mode = 2'd3;
      delay_amt  = 32'd2;
      repeat (10) step(1'b1, 1'b1);
      repeat (6)  step(1'b0, 1'b1);

      // Reset with three messages queued, then check LFSR reseed via RANDOM
      delay_mode = 2'd0;
      delay_amt  = 32'd20;
      repeat (3) step(1'b1, 1'b0);
      trace();
      reset = 1'b1;
      step(1'b0, 1'b1);
      reset = 1'b0;
      step(1'b0, 1'b1);
      delay_mode = 2'd1;
      delay_amt  = 32'd5;
      for (int i = 0; i < 40; i++) begin
         v = ($urandom_range(0, 1) == 1);
         r = ($urandom_range(0, 2) != 0);
         step(v, r);
      end
      repeat (20) step(1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
